// File: rtl/conv_pkg.sv
// Shared encodings for the convolution tile scheduler: FSM states, dim-field
// slices, {row,col} address layout, skew-line entry and row-major walk helper.
package conv_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FEED, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  localparam int FIELD_W       = 4;
  localparam int DIM_ROW_LSB   = 4;
  localparam int DIM_COL_LSB   = 0;
  localparam int ADDR_W        = 2 * FIELD_W;
  localparam int DRAIN_CYC_DEF = 4;

  typedef struct packed {
    logic [FIELD_W-1:0] row;
    logic [FIELD_W-1:0] col;
  } addr_t;

  typedef struct packed {
    logic               vld;
    logic [FIELD_W-1:0] ky;
    logic [FIELD_W-1:0] kx;
  } skew_t;

  // Row carries a spare bit so a walk past the last output row stays visible.
  typedef struct packed {
    logic [FIELD_W:0]   row;
    logic [FIELD_W-1:0] col;
  } pos_t;

  function automatic pos_t pos_step(input pos_t p, input logic [FIELD_W-1:0] ow);
    pos_t n;
    if (p.col == ow - FIELD_W'(1)) begin
      n.row = p.row + (FIELD_W+1)'(1);
      n.col = '0;
    end else begin
      n.row = p.row;
      n.col = p.col + FIELD_W'(1);
    end
    return n;
  endfunction
endpackage

// File: rtl/conv_skew_shift.sv
// Kernel-entry delay line: taps[c] is the entry column c will present next cycle,
// i.e. the input delayed by c cycles.
module conv_skew_shift
  import conv_pkg::*;
#(
  parameter int N_COLS = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  skew_t               entry,
  output skew_t [N_COLS-1:0]  taps
);
  assign taps[0] = entry;

  generate
    if (N_COLS > 1) begin : g_dly
      skew_t [N_COLS-2:0] dly;
      always_ff @(posedge clk) begin
        if (reset) begin
          dly <= '0;
        end else begin
          dly[0] <= entry;
          for (int c = 1; c < N_COLS - 1; c++) dly[c] <= dly[c-1];
        end
      end
      assign taps[N_COLS-1:1] = dly;
    end
  endgenerate
endmodule

// File: rtl/conv_tile_scheduler.sv
// Tile sequencer for the systolic convolution array: FEED/CAPTURE/DRAIN per tile.
// Optional CONV_SCHED_PERF_EN adds a saturating busy-cycle counter (perf_cycles).
module conv_tile_scheduler
  import conv_pkg::*;
#(
  parameter int N_COLS    = 9,
  parameter int DIM_W     = 4,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 img_d,
  input  logic [7:0]                 ker_d,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [N_COLS-1:0]          col_en,
  output logic [N_COLS*ADDR_W-1:0]   img_addr,
  output logic                       ker_en,
  output logic [ADDR_W-1:0]          ker_addr,
  output logic                       sa_load,
  output logic [CNT_W-1:0]           tile_idx
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [15:0]                perf_cycles
`endif
);
  state_t             state, state_n;
  logic [CNT_W-1:0]   t, t_n, dcnt, dcnt_n, tile_n, k_tot, k_n;
  logic [DIM_W-1:0]   oh, oh_n, ow, ow_n, kw, kw_n;
  logic [FIELD_W-1:0] ky, ky_n, kx, kx_n, by, by_n, bx, bx_n;
  logic [DIM_W-1:0]   ih_in, iw_in, kh_in, kw_in;
  logic               err_n, dims_bad;
  pos_t               next_base;
  skew_t              skew_in;
  skew_t [N_COLS-1:0] taps;
  logic [N_COLS-1:0]        col_en_n;
  logic [N_COLS*ADDR_W-1:0] img_addr_n;

  assign ih_in = img_d[DIM_ROW_LSB +: DIM_W];
  assign iw_in = img_d[DIM_COL_LSB +: DIM_W];
  assign kh_in = ker_d[DIM_ROW_LSB +: DIM_W];
  assign kw_in = ker_d[DIM_COL_LSB +: DIM_W];
  assign dims_bad = (ih_in == '0) || (iw_in == '0) || (kh_in == '0) || (kw_in == '0) ||
                    (kh_in > ih_in) || (kw_in > iw_in);

  // Base of the following tile: N_COLS row-major steps from the current base.
  always_comb begin
    pos_t w;
    w = {1'b0, by, bx};
    for (int i = 0; i < N_COLS; i++) w = pos_step(w, ow);
    next_base = w;
  end

  always_comb begin
    state_n = state;
    t_n = t; dcnt_n = dcnt; tile_n = tile_idx;
    ky_n = ky; kx_n = kx; by_n = by; bx_n = bx;
    oh_n = oh; ow_n = ow; kw_n = kw; k_n = k_tot;
    err_n = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        if (dims_bad) begin
          err_n = 1'b1;
        end else begin
          state_n = S_FEED;
          t_n = '0; tile_n = '0;
          ky_n = '0; kx_n = '0; by_n = '0; bx_n = '0;
          oh_n = ih_in - kh_in + DIM_W'(1);
          ow_n = iw_in - kw_in + DIM_W'(1);
          kw_n = kw_in;
          k_n  = CNT_W'(kh_in) * CNT_W'(kw_in);
        end
      end
      S_FEED: begin
        if (int'(t) == int'(k_tot) + N_COLS - 2) begin
          state_n = S_CAPTURE;
        end else begin
          t_n = t + CNT_W'(1);
          if (kx == kw - DIM_W'(1)) begin
            kx_n = '0;
            ky_n = ky + FIELD_W'(1);
          end else begin
            kx_n = kx + FIELD_W'(1);
          end
        end
      end
      S_CAPTURE: begin
        state_n = S_DRAIN;
        dcnt_n  = '0;
      end
      S_DRAIN: begin
        if (int'(dcnt) == DRAIN_CYC - 1) begin
          if (next_base.row < {1'b0, oh}) begin
            state_n = S_FEED;
            t_n = '0; ky_n = '0; kx_n = '0;
            tile_n = tile_idx + CNT_W'(1);
            by_n = next_base.row[FIELD_W-1:0];
            bx_n = next_base.col;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          dcnt_n = dcnt + CNT_W'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign skew_in = {(state_n == S_FEED) && (t_n < k_n), ky_n, kx_n};

  conv_skew_shift #(.N_COLS(N_COLS)) u_skew (
    .clk   (clk),
    .reset (reset),
    .entry (skew_in),
    .taps  (taps)
  );

  // Column c sits c row-major steps past the tile base; p>=P shows up as row>=OH.
  always_comb begin
    pos_t w;
    w = {1'b0, by_n, bx_n};
    col_en_n   = '0;
    img_addr_n = '0;
    for (int c = 0; c < N_COLS; c++) begin
      if (taps[c].vld && (w.row < {1'b0, oh_n})) begin
        col_en_n[c] = 1'b1;
        img_addr_n[c*ADDR_W +: ADDR_W] = {w.row[FIELD_W-1:0] + taps[c].ky, w.col + taps[c].kx};
      end
      w = pos_step(w, ow_n);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      t <= '0; dcnt <= '0; k_tot <= '0;
      oh <= '0; ow <= '0; kw <= '0;
      ky <= '0; kx <= '0; by <= '0; bx <= '0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0; sa_load <= 1'b0;
      ker_en <= 1'b0; ker_addr <= '0; tile_idx <= '0;
      col_en <= '0; img_addr <= '0;
    end else begin
      state <= state_n;
      t <= t_n; dcnt <= dcnt_n; k_tot <= k_n;
      oh <= oh_n; ow <= ow_n; kw <= kw_n;
      ky <= ky_n; kx <= kx_n; by <= by_n; bx <= bx_n;
      busy     <= (state_n == S_FEED) || (state_n == S_CAPTURE) || (state_n == S_DRAIN);
      done     <= (state_n == S_DONE);
      sa_load  <= (state_n == S_CAPTURE);
      err      <= err_n;
      ker_en   <= skew_in.vld;
      ker_addr <= skew_in.vld ? {ky_n, kx_n} : '0;
      tile_idx <= tile_n;
      col_en   <= col_en_n;
      img_addr <= img_addr_n;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) perf_cycles <= '0;
    else if ((state == S_IDLE) && (state_n == S_FEED)) perf_cycles <= '0;
    else if (busy && (perf_cycles != 16'hFFFF)) perf_cycles <= perf_cycles + 16'd1;
  end
`endif
endmodule
